// File: rtl/cpu_pkg.sv
// Shared constants for the five-stage MIPS core: NOP control word, reset PC,
// exception codes and the Tnew/Tuse field width.
// Latency: n/a (constants only). Backpressure: n/a.
package cpu_pkg;

   localparam int TNEW_W    = 3;
   localparam int CTRL_BITS = 60;

   // Bit 0 of the one-hot instruction-type vector is sll; sll $0,$0,0 is the NOP.
   localparam logic [CTRL_BITS-1:0] CTRL_NOP = 60'h1;
   localparam logic [31:0]          RESET_PC = 32'h0000_3000;
   localparam logic [4:0]           EXC_RI   = 5'd10;

endpackage

// File: rtl/fwd_sel.sv
// ID-stage operand forwarding: priority match over NUM_FWD sources, data mux, pending flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none here; pend tells the hazard logic to stall the operand's consumer.
//
// Ports: addr (register number), rf_data (raw GRF read), fwd_wa/fwd_data/fwd_ok
// (packed per-source destination, value, value-valid; index 0 = youngest),
// data (forwarded operand), pend (winning source has no value yet).
module fwd_sel #(
   parameter int XLEN    = 32,
   parameter int NUM_FWD = 3
) (
   input  logic [4:0]              addr,
   input  logic [XLEN-1:0]         rf_data,
   input  logic [5*NUM_FWD-1:0]    fwd_wa,
   input  logic [XLEN*NUM_FWD-1:0] fwd_data,
   input  logic [NUM_FWD-1:0]      fwd_ok,
   output logic [XLEN-1:0]         data,
   output logic                    pend
);

   logic found;

   // Lowest index is the youngest producer, so the first hit wins.
   always_comb begin
      data  = rf_data;
      pend  = 1'b0;
      found = 1'b0;
      for (int i = 0; i < NUM_FWD; i++) begin
         if (!found && (addr != 5'd0) && (fwd_wa[i*5 +: 5] == addr)) begin
            found = 1'b1;
            pend  = ~fwd_ok[i];
            if (fwd_ok[i])
               data = fwd_data[i*XLEN +: XLEN];
         end
      end
      if (addr == 5'd0)
         data = '0;
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with ID-stage forwarding, bubble/hold/flush, Tnew countdown, exception merge.
// Latency: forwarding/pend combinational; ID->EX fields 1 cycle.
// Backpressure: hold freezes the register (Tnew still counts down); bubble inserts a NOP.
//
// Ports: clk/reset (sync, active-high); id_* decoded instruction and GRF read data;
// if_exc/if_exc_code from IF; fwd_wa/fwd_data/fwd_ok downstream producers;
// bubble/hold/flush controls; id_rs_data/id_rt_data/id_*_pend comb forwarding results;
// ex_* registered instruction for EX, ex_exc/ex_exc_code merged status, ex_bd delay-slot flag.
// Build option: define ID_EX_DELAY_SLOT_EN to track branch delay slots (else ex_bd is 0).
module id_ex_stage
   import cpu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int NUM_FWD = 3,
   parameter int CTRL_W  = 60,
   parameter int TW      = TNEW_W
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    id_valid,
   input  logic [XLEN-1:0]         id_pc,
   input  logic [CTRL_W-1:0]       id_ctrl,
   input  logic [4:0]              id_rs,
   input  logic [4:0]              id_rt,
   input  logic [4:0]              id_wa,
   input  logic [XLEN-1:0]         id_rs_rf,
   input  logic [XLEN-1:0]         id_rt_rf,
   input  logic [XLEN-1:0]         id_imm,
   input  logic [XLEN-1:0]         id_res,
   input  logic [TW-1:0]           id_tnew,
   input  logic                    id_is_jb,
   input  logic                    id_ri,
   input  logic                    if_exc,
   input  logic [4:0]              if_exc_code,
   input  logic [5*NUM_FWD-1:0]    fwd_wa,
   input  logic [XLEN*NUM_FWD-1:0] fwd_data,
   input  logic [NUM_FWD-1:0]      fwd_ok,
   input  logic                    bubble,
   input  logic                    hold,
   input  logic                    flush,
   output logic [XLEN-1:0]         id_rs_data,
   output logic [XLEN-1:0]         id_rt_data,
   output logic                    id_rs_pend,
   output logic                    id_rt_pend,
   output logic                    ex_valid,
   output logic [XLEN-1:0]         ex_pc,
   output logic [CTRL_W-1:0]       ex_ctrl,
   output logic [4:0]              ex_rs,
   output logic [4:0]              ex_rt,
   output logic [4:0]              ex_wa,
   output logic [XLEN-1:0]         ex_rs_data,
   output logic [XLEN-1:0]         ex_rt_data,
   output logic [XLEN-1:0]         ex_imm,
   output logic [XLEN-1:0]         ex_res,
   output logic [TW-1:0]           ex_tnew,
   output logic                    ex_exc,
   output logic [4:0]              ex_exc_code,
   output logic                    ex_bd
);

   fwd_sel #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs (
      .addr(id_rs), .rf_data(id_rs_rf), .fwd_wa(fwd_wa), .fwd_data(fwd_data),
      .fwd_ok(fwd_ok), .data(id_rs_data), .pend(id_rs_pend)
   );

   fwd_sel #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rt (
      .addr(id_rt), .rf_data(id_rt_rf), .fwd_wa(fwd_wa), .fwd_data(fwd_data),
      .fwd_ok(fwd_ok), .data(id_rt_data), .pend(id_rt_pend)
   );

   // IF-stage exception is older than the decode-time one, so it keeps its code.
   logic       ld_exc;
   logic [4:0] ld_code;

   always_comb begin
      ld_exc  = if_exc | id_ri;
      ld_code = 5'd0;
      if (if_exc)
         ld_code = if_exc_code;
      else if (id_ri)
         ld_code = EXC_RI;
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         ex_valid    <= 1'b0;
         ex_pc       <= XLEN'(RESET_PC);
         ex_ctrl     <= CTRL_W'(CTRL_NOP);
         ex_rs       <= '0;
         ex_rt       <= '0;
         ex_wa       <= '0;
         ex_rs_data  <= '0;
         ex_rt_data  <= '0;
         ex_imm      <= '0;
         ex_res      <= '0;
         ex_tnew     <= '0;
         ex_exc      <= 1'b0;
         ex_exc_code <= '0;
      end else if (hold) begin
         // Result keeps maturing while EX is stalled; saturate at zero.
         if (ex_tnew != '0)
            ex_tnew <= ex_tnew - TW'(1);
      end else if (bubble) begin
         // PC of the stalled instruction is kept so an interrupt on the bubble has a valid EPC.
         ex_valid    <= 1'b0;
         ex_pc       <= id_pc;
         ex_ctrl     <= CTRL_W'(CTRL_NOP);
         ex_wa       <= '0;
         ex_tnew     <= '0;
         ex_exc      <= 1'b0;
         ex_exc_code <= '0;
      end else begin
         ex_valid    <= id_valid;
         ex_pc       <= id_pc;
         ex_ctrl     <= id_ctrl;
         ex_rs       <= id_rs;
         ex_rt       <= id_rt;
         ex_wa       <= ld_exc ? 5'd0 : id_wa;
         ex_rs_data  <= id_rs_data;
         ex_rt_data  <= id_rt_data;
         ex_imm      <= id_imm;
         ex_res      <= id_res;
         ex_tnew     <= id_tnew;
         ex_exc      <= ld_exc;
         ex_exc_code <= ld_code;
      end
   end

`ifdef ID_EX_DELAY_SLOT_EN
   // prev_jb: the last real instruction sent to EX was a branch/jump, so whatever
   // enters EX next (bubble or instruction) sits in its delay slot.
   logic prev_jb;
   logic bd_q;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         prev_jb <= 1'b0;
         bd_q    <= 1'b0;
      end else if (hold) begin
         bd_q    <= bd_q;
      end else if (bubble) begin
         bd_q    <= prev_jb;
      end else begin
         bd_q    <= prev_jb;
         if (id_valid)
            prev_jb <= id_is_jb;
      end
   end

   assign ex_bd = bd_q;
`else
   logic unused_id_is_jb;
   assign unused_id_is_jb = id_is_jb;
   assign ex_bd           = 1'b0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed cases then randomized traffic against a reference model.
// Latency: expectations are queued one edge ahead and popped by a monitor after each rising edge.
// Backpressure: hold/bubble/flush are driven randomly; loads never carry a pending operand.
module tb_id_ex_stage;
   import cpu_pkg::*;

`ifdef ID_EX_DELAY_SLOT_EN
   localparam bit DS_EN = 1'b1;
`else
   localparam bit DS_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, id_valid, id_is_jb, id_ri, if_exc, bubble, hold, flush;
   logic [31:0] id_pc, id_rs_rf, id_rt_rf, id_imm, id_res;
   logic [59:0] id_ctrl;
   logic [4:0]  id_rs, id_rt, id_wa, if_exc_code;
   logic [2:0]  id_tnew;
   logic [14:0] fwd_wa;
   logic [95:0] fwd_data;
   logic [2:0]  fwd_ok;
   logic [31:0] id_rs_data, id_rt_data, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_res;
   logic        id_rs_pend, id_rt_pend, ex_valid, ex_exc, ex_bd;
   logic [59:0] ex_ctrl;
   logic [4:0]  ex_rs, ex_rt, ex_wa, ex_exc_code;
   logic [2:0]  ex_tnew;

   id_ex_stage dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc), .id_ctrl(id_ctrl),
      .id_rs(id_rs), .id_rt(id_rt), .id_wa(id_wa), .id_rs_rf(id_rs_rf), .id_rt_rf(id_rt_rf),
      .id_imm(id_imm), .id_res(id_res), .id_tnew(id_tnew), .id_is_jb(id_is_jb), .id_ri(id_ri),
      .if_exc(if_exc), .if_exc_code(if_exc_code), .fwd_wa(fwd_wa), .fwd_data(fwd_data),
      .fwd_ok(fwd_ok), .bubble(bubble), .hold(hold), .flush(flush),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_rs_pend(id_rs_pend),
      .id_rt_pend(id_rt_pend), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_ctrl(ex_ctrl),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wa(ex_wa), .ex_rs_data(ex_rs_data),
      .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_res(ex_res), .ex_tnew(ex_tnew),
      .ex_exc(ex_exc), .ex_exc_code(ex_exc_code), .ex_bd(ex_bd)
   );

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic [59:0] ctrl;
      logic [4:0]  rs, rt, wa;
      logic [31:0] rs_data, rt_data, imm, res;
      logic [2:0]  tnew;
      logic        exc;
      logic [4:0]  code;
      logic        bd;
   } st_t;

   st_t  m;
   logic m_pjb;
   st_t  sbq[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic st_t rst_state();
      st_t s;
      s = '{valid: 1'b0, pc: RESET_PC, ctrl: CTRL_NOP, rs: 5'd0, rt: 5'd0, wa: 5'd0,
            rs_data: 32'd0, rt_data: 32'd0, imm: 32'd0, res: 32'd0, tnew: 3'd0,
            exc: 1'b0, code: 5'd0, bd: 1'b0};
      return s;
   endfunction

   // {pend, data}: youngest source naming the register decides; $0 is always zero.
   function automatic logic [32:0] ref_fwd(input logic [4:0] a, input logic [31:0] rf);
      if (a == 5'd0) return 33'd0;
      for (int i = 0; i < 3; i++)
         if (fwd_wa[i*5 +: 5] == a)
            return fwd_ok[i] ? {1'b0, fwd_data[i*32 +: 32]} : {1'b1, rf};
      return {1'b0, rf};
   endfunction

   // Called at a falling edge with inputs already applied; returns at the next falling edge.
   task automatic step();
      logic [32:0] fs, ft;
      st_t n;
      fs = ref_fwd(id_rs, id_rs_rf);
      ft = ref_fwd(id_rt, id_rt_rf);
      #1;
      chk("id_rs_pend", id_rs_pend, fs[32]);
      chk("id_rt_pend", id_rt_pend, ft[32]);
      if (!fs[32]) chk("id_rs_data", id_rs_data, fs[31:0]);
      if (!ft[32]) chk("id_rt_data", id_rt_data, ft[31:0]);
      n = m;
      if (reset || flush) begin
         n     = rst_state();
         m_pjb = 1'b0;
      end else if (hold) begin
         if (m.tnew != 3'd0) n.tnew = m.tnew - 3'd1;
      end else if (bubble) begin
         n.valid = 1'b0; n.ctrl = CTRL_NOP; n.wa = 5'd0; n.tnew = 3'd0;
         n.exc = 1'b0; n.code = 5'd0; n.pc = id_pc; n.bd = DS_EN & m_pjb;
      end else begin
         n.valid = id_valid; n.pc = id_pc; n.ctrl = id_ctrl; n.rs = id_rs; n.rt = id_rt;
         n.rs_data = fs[31:0]; n.rt_data = ft[31:0]; n.imm = id_imm; n.res = id_res;
         n.tnew = id_tnew;
         n.exc  = if_exc | id_ri;
         n.code = if_exc ? if_exc_code : (id_ri ? 5'd10 : 5'd0);
         n.wa   = n.exc ? 5'd0 : id_wa;
         n.bd   = DS_EN & m_pjb;
         if (id_valid) m_pjb = id_is_jb;
      end
      m = n;
      sbq.push_back(n);
      @(negedge clk);
   endtask

   initial begin : monitor
      st_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("ex_valid", ex_valid, e.valid);
            chk("ex_pc", ex_pc, e.pc);
            chk("ex_ctrl", ex_ctrl, e.ctrl);
            chk("ex_rs", ex_rs, e.rs);
            chk("ex_rt", ex_rt, e.rt);
            chk("ex_wa", ex_wa, e.wa);
            chk("ex_rs_data", ex_rs_data, e.rs_data);
            chk("ex_rt_data", ex_rt_data, e.rt_data);
            chk("ex_imm", ex_imm, e.imm);
            chk("ex_res", ex_res, e.res);
            chk("ex_tnew", ex_tnew, e.tnew);
            chk("ex_exc", ex_exc, e.exc);
            chk("ex_exc_code", ex_exc_code, e.code);
            chk("ex_bd", ex_bd, e.bd);
         end
      end
   end

   task automatic idle();
      reset = 1'b0; id_valid = 1'b0; id_is_jb = 1'b0; id_ri = 1'b0; if_exc = 1'b0;
      bubble = 1'b0; hold = 1'b0; flush = 1'b0;
      id_pc = 32'h0000_3000; id_rs_rf = 32'd0; id_rt_rf = 32'd0; id_imm = 32'd0; id_res = 32'd0;
      id_ctrl = CTRL_NOP; id_rs = 5'd0; id_rt = 5'd0; id_wa = 5'd0; if_exc_code = 5'd0;
      id_tnew = 3'd0; fwd_wa = 15'd0; fwd_data = 96'd0; fwd_ok = 3'b111;
   endtask

   task automatic load_insn(input logic [31:0] pc, input logic [4:0] wa, input logic [2:0] tn,
                            input logic jb);
      idle();
      id_valid = 1'b1; id_pc = pc; id_ctrl = 60'h4; id_rs = 5'd1; id_rt = 5'd2; id_wa = wa;
      id_rs_rf = 32'h1111; id_rt_rf = 32'h2222; id_imm = 32'h10; id_tnew = tn; id_is_jb = jb;
   endtask

   localparam logic [31:0] DA = 32'hAAAA_0001;
   localparam logic [31:0] DB = 32'hBBBB_0002;
   localparam logic [31:0] DC = 32'hCCCC_0003;

   initial begin : driver
      logic [32:0] pr, pt;
      m     = rst_state();
      m_pjb = 1'b0;
      idle();
      reset = 1'b1;
      @(negedge clk);
      step();
      step();

      // Forwarding priority: all three sources name r5, youngest wins.
      idle();
      id_rs = 5'd5; id_rs_rf = 32'h5555; fwd_wa = {5'd5, 5'd5, 5'd5}; fwd_data = {DC, DB, DA};
      #1;
      chk("prio_src0", id_rs_data, DA);
      step();
      fwd_ok = 3'b110;
      #1;
      chk("prio_pend", id_rs_pend, 1'b1);
      bubble = 1'b1;
      step();
      idle();
      id_rs = 5'd0; id_rs_rf = 32'hDEAD; fwd_wa = 15'd0; fwd_data = {DC, DB, DA};
      #1;
      chk("r0_data", id_rs_data, 32'd0);
      chk("r0_pend", id_rs_pend, 1'b0);
      step();

      // Bubble keeps the stalled PC.
      idle(); id_pc = 32'h0000_3010; id_wa = 5'd7; id_valid = 1'b1; bubble = 1'b1;
      step();

      // Tnew counts down under hold and saturates; flush beats hold.
      load_insn(32'h3020, 5'd9, 3'd2, 1'b0);
      step();
      idle(); hold = 1'b1;
      step(); step(); step();
      flush = 1'b1;
      step();

      // Exception merge.
      load_insn(32'h3030, 5'd8, 3'd1, 1'b0); if_exc = 1'b1; if_exc_code = 5'd4; id_ri = 1'b1;
      step();
      load_insn(32'h3034, 5'd8, 3'd1, 1'b0); id_ri = 1'b1;
      step();

      // Delay slot tracking: beq, bubble, add, next.
      load_insn(32'h3040, 5'd0, 3'd0, 1'b1);
      step();
      idle(); id_pc = 32'h3044; bubble = 1'b1;
      step();
      load_insn(32'h3044, 5'd3, 3'd1, 1'b0);
      step();
      load_insn(32'h3048, 5'd4, 3'd1, 1'b0);
      step();

      // Reset in the middle of a hold.
      load_insn(32'h3050, 5'd6, 3'd3, 1'b0);
      step();
      idle(); hold = 1'b1;
      step();
      reset = 1'b1;
      step();

      for (int c = 0; c < 800; c++) begin
         idle();
         id_valid = ($urandom_range(7, 0) != 0);
         id_pc = $urandom; id_ctrl = 60'(1) << $urandom_range(59, 0);
         id_rs = 5'($urandom_range(7, 0)); id_rt = 5'($urandom_range(7, 0));
         id_wa = 5'($urandom_range(7, 0));
         id_rs_rf = $urandom; id_rt_rf = $urandom; id_imm = $urandom; id_res = $urandom;
         id_tnew = 3'($urandom_range(7, 0)); id_is_jb = $urandom_range(1, 0) == 1;
         id_ri = ($urandom_range(7, 0) == 0); if_exc = ($urandom_range(7, 0) == 0);
         if_exc_code = 5'($urandom_range(31, 0));
         for (int i = 0; i < 3; i++) begin
            fwd_wa[i*5 +: 5]    = 5'($urandom_range(7, 0));
            fwd_data[i*32 +: 32] = $urandom;
            fwd_ok[i]           = ($urandom_range(3, 0) != 0);
         end
         bubble = ($urandom_range(5, 0) == 0);
         hold   = ($urandom_range(5, 0) == 0);
         flush  = ($urandom_range(11, 0) == 0);
         reset  = ($urandom_range(39, 0) == 0);
         pr = ref_fwd(id_rs, id_rs_rf);
         pt = ref_fwd(id_rt, id_rt_rf);
         if (pr[32] || pt[32]) bubble = 1'b1;
         step();
      end

      idle();
      repeat (3) @(posedge clk);
      #2;
      chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Parametrised decode-to-execute pipeline stage for the five-stage MIPS core. It resolves ID-stage operand forwarding from NUM_FWD downstream sources and flags operands that are not yet available. It registers the decoded instruction into EX with separate bubble, hold and flush controls, a self-decrementing Tnew field, merged exception status and branch-delay-slot tracking. It sits between the decoder/GRF read ports and the EX stage, and replaces the fixed two-source, clear-on-stall ID/EX register.

## Interface
- XLEN, 32, datapath width
- NUM_FWD, 3, forwarding sources; index 0 = youngest (EX), highest priority
- CTRL_W, 60, width of one-hot instruction-type vector
- TW, 3, Tnew/Tuse field width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of ID instruction
- id_ctrl  in  CTRL_W  decoded instruction type
- id_rs, id_rt, id_wa  in  5 each  source/dest register numbers (wa=0: no write)
- id_rs_rf, id_rt_rf  in  XLEN each  raw GRF read data
- id_imm, id_res  in  XLEN each  extended immediate; result produced in ID (lui/link)
- id_tnew  in  TW  cycles until result ready, counted from EX entry
- id_is_jb  in  1  instruction is a branch/jump
- id_ri  in  1  reserved instruction detected by decoder
- if_exc, if_exc_code  in  1, 5  exception carried from IF
- fwd_wa  in  5*NUM_FWD  destination of each source
- fwd_data  in  XLEN*NUM_FWD  value of each source
- fwd_ok  in  NUM_FWD  value of source valid this cycle
- bubble, hold, flush  in  1 each  hazard stall; downstream busy; exception flush
- id_rs_data, id_rt_data  out  XLEN each  forwarded operands (comb., for branch compare/jr)
- id_rs_pend, id_rt_pend  out  1 each  highest-priority match has fwd_ok=0
- ex_valid, ex_pc, ex_ctrl, ex_rs, ex_rt, ex_wa, ex_rs_data, ex_rt_data, ex_imm, ex_res, ex_tnew  out  registered copies
- ex_exc, ex_exc_code, ex_bd  out  1, 5, 1

## Operation
- Forwarding, per operand: scan sources 0..NUM_FWD-1; first with fwd_wa==addr and addr!=0 wins. Data from winner if fwd_ok, pend=1 if not. No match or addr==0 -> GRF data, pend=0. Register 0 always reads 0.
- Register update priority per cycle: reset > flush > hold > bubble > load.
- reset/flush: ex_valid=0, ex_ctrl=CTRL_NOP, ex_pc=RESET_PC, all other fields 0, ex_exc=0, ex_exc_code=0, ex_bd=0, prev_jb=0.
- hold: every field keeps its value except ex_tnew = max(ex_tnew-1, 0).
- bubble: ex_valid=0, ex_ctrl=CTRL_NOP, ex_wa=0, ex_tnew=0, ex_exc=0, ex_pc=id_pc, ex_bd=prev_jb. Bubble PC is kept so that an interrupt taken on a bubble reports a correct EPC.
- load: all fields from ID; ex_valid=id_valid; operands from forwarded values.
- Exception merge on load: if_exc has priority and keeps if_exc_code. Else id_ri gives code EXC_RI (10). Else ex_exc=0, code 0.
- Loading with ex_exc=1 forces ex_wa=0 (no architectural write).

## Timing
- Forwarding and pend are purely combinational from inputs, with zero latency.
- ID->EX latency is 1 cycle.
- ex_tnew counts down only in hold; it never underflows.
- flush asserted together with hold or bubble: flush wins the same edge.
- reset mid-hold: all outputs return to their reset values on the next edge.

## Configuration
- ID_EX_DELAY_SLOT_EN defined: internal prev_jb is set on a load with id_valid & id_is_jb. It is cleared on a load with id_valid & !id_is_jb. It is unaffected by hold and bubble, and cleared by reset/flush. On load, ex_bd=prev_jb.
- Not defined: prev_jb is absent and ex_bd is tied 0.

## Structure
- Shared package cpu_pkg holds CTRL_NOP (the sll one-hot), RESET_PC (32'h0000_3000), EXC_RI (5'd10) and the Tnew width constant.
- The sub-module fwd_sel holds the NUM_FWD priority match, mux and pend logic. It is instantiated once for rs and once for rt.

## Test plan
- Reset: hold reset 2 cycles -> ex_valid=0, ex_pc=32'h0000_3000, ex_ctrl=CTRL_NOP, ex_bd=0.
- Priority: rs=5, fwd_wa={5,5,5}, data {A,B,C}, ok all 1 -> id_rs_data=A (source 0). With fwd_ok[0]=0 -> id_rs_pend=1. rs=0 matching wa=0 -> data 0, pend 0.
- Bubble: id_pc=0x3010, bubble=1 -> ex_valid=0, ex_pc=0x3010, ex_wa=0.
- Hold: load id_tnew=2, then hold 3 cycles -> ex_tnew 1, 0, 0, with all other fields unchanged. flush together with hold -> NOP at the next edge.
- Exceptions: if_exc=1 code 4 together with id_ri=1 -> ex_exc_code=4, ex_wa=0. id_ri alone -> code 10.
- Delay slot (macro on): load beq (id_is_jb=1), then bubble, then load add -> bubble ex_bd=1, add ex_bd=1, next instruction ex_bd=0. With the macro off, ex_bd stays 0.
